hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 39 +++
 rtl/hazard_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_e : load-use FSM state (HZ_RUN, HZ_STALL)
//   FWD_*      : operand source codes driven on fwd_a / fwd_b
//   GR0        : index of the hardwired-zero register (never a real dependency)
package hazard_pkg;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned GR0 = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: source select for one ID-stage operand.
// Ports:
//   src               in  register read by the operand
//   ex_rd/ex_rf_le    in  EX destination and write enable
//   ex_load           in  EX is a load (its data is not ready, so no EX bypass)
//   mem_rd/mem_rf_le  in  MEM destination and write enable
//   wb_rd/wb_rf_le    in  WB destination and write enable
//   sel               out FWD_RF / FWD_EX / FWD_MEM / FWD_WB, youngest producer wins
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_le,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_le,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_le,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    // GR0 always reads as zero from the register file, whatever is in flight.
    if (src != REG_AW'(GR0)) begin
      if (src == ex_rd && ex_rf_le && !ex_load) begin
        sel = FWD_EX;
      end else if (src == mem_rd && mem_rf_le) begin
        sel = FWD_MEM;
      end else if (src == wb_rd && wb_rf_le) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall FSM, branch flush and operand forwarding
// selects for the ID stage.
// Parameters:
//   LOAD_STALL_CYCLES  bubbles per load-use hazard, legal range 1..3
//   REG_AW             register-address width
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_ra/id_rb, id_use_ra/_rb      ID source registers and their read flags
//   ex_rd, ex_rf_le, ex_load        EX destination, write enable, load flag
//   mem_rd, mem_rf_le               MEM destination, write enable
//   wb_rd, wb_rf_le                 WB destination, write enable
//   br_taken                        branch resolved taken in EX
//   nop_sel                         1 zeroes all control fields (CU NOP mux)
//   pc_le, if_id_le, if_id_flush    fetch-stage enables and IF/ID flush
//   fwd_a, fwd_b                    operand source selects
//   stall_count, flush_count        saturating statistics counters
//   fsm_state                       current FSM state, for observation
// Optional build macro: HAZARD_STATS_EN enables the statistics counters;
// without it both counter ports are tied to zero.
//
// Handshake note: there is no valid/ready here; control outputs are purely
// combinational from inputs and state, and the state advances on every clk.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_AW            = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_le,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_le,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_le,
  input  logic              br_taken,
  output logic              nop_sel,
  output logic              pc_le,
  output logic              if_id_le,
  output logic              if_id_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count,
  output hz_state_e         fsm_state
);

  // Bubbles still owed after the detection cycle.
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hit_a, hit_b, load_use;
  logic [1:0] sel_a, sel_b;

  assign hit_a = id_use_ra && (id_ra != REG_AW'(GR0)) && ex_load && ex_rf_le && (ex_rd == id_ra);
  assign hit_b = id_use_rb && (id_rb != REG_AW'(GR0)) && ex_load && ex_rf_le && (ex_rd == id_rb);
  assign load_use = hit_a || hit_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nop_sel     = 1'b0;
    pc_le       = 1'b1;
    if_id_le    = 1'b1;
    if_id_flush = 1'b0;
    if (!rst_n) begin
      // Hold the pipeline frozen with a bubble while reset is asserted.
      nop_sel  = 1'b1;
      pc_le    = 1'b0;
      if_id_le = 1'b0;
    end else if (br_taken) begin
      // Flush wins over any stall; a pending load-use is on the wrong path.
      nop_sel     = 1'b1;
      if_id_flush = 1'b1;
      state_d     = HZ_RUN;
      cnt_d       = 2'd0;
    end else if (state_q == HZ_STALL) begin
      nop_sel  = 1'b1;
      pc_le    = 1'b0;
      if_id_le = 1'b0;
      if (cnt_q == 2'd1) begin
        state_d = HZ_RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (load_use) begin
      nop_sel  = 1'b1;
      pc_le    = 1'b0;
      if_id_le = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = HZ_STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src(id_ra), .ex_rd(ex_rd), .ex_rf_le(ex_rf_le), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_le(mem_rf_le), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le),
    .sel(sel_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src(id_rb), .ex_rd(ex_rd), .ex_rf_le(ex_rf_le), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_le(mem_rf_le), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le),
    .sel(sel_b)
  );

  assign fwd_a     = rst_n ? sel_a : FWD_RF;
  assign fwd_b     = rst_n ? sel_b : FWD_RF;
  assign fsm_state = state_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_le && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (if_id_flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed and randomised checks of hazard_ctrl_unit.
// Two instances share all inputs: one with LOAD_STALL_CYCLES=1, one with 3.
// Expected vector per cycle: {nop_sel, pc_le, if_id_le, if_id_flush, fwd_a, fwd_b, state}.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT inputs ----------------
  logic [AW-1:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic id_use_ra, id_use_rb, ex_rf_le, ex_load, mem_rf_le, wb_rf_le, br_taken;

  // ---------------- DUT outputs ----------------
  logic nop1, pc1, ifid1, fl1, nop3, pc3, ifid3, fl3;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [15:0] sc1, fc1, sc3, fc3;
  hz_state_e st1, st3;

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .REG_AW(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rd(ex_rd),
    .ex_rf_le(ex_rf_le), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_rf_le(mem_rf_le), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le),
    .br_taken(br_taken), .nop_sel(nop1), .pc_le(pc1), .if_id_le(ifid1),
    .if_id_flush(fl1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1),
    .flush_count(fc1), .fsm_state(st1)
  );

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .REG_AW(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rd(ex_rd),
    .ex_rf_le(ex_rf_le), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_rf_le(mem_rf_le), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le),
    .br_taken(br_taken), .nop_sel(nop3), .pc_le(pc3), .if_id_le(ifid3),
    .if_id_flush(fl3), .fwd_a(fa3), .fwd_b(fb3), .stall_count(sc3),
    .flush_count(fc3), .fsm_state(st3)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp1_q[$];
  logic [8:0] exp3_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // control nibble {nop_sel, pc_le, if_id_le, if_id_flush}
  localparam logic [3:0] C_RUN   = 4'b0110;
  localparam logic [3:0] C_STALL = 4'b1000;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RST   = 4'b1000;

  function automatic logic [8:0] ev(logic [3:0] c, logic [1:0] fa, logic [1:0] fb, logic st);
    return {c, fa, fb, st};
  endfunction

  // Independent forwarding model: scan producers oldest to youngest,
  // letting each younger valid producer overwrite the choice.
  function automatic logic [1:0] fwd_model(logic [AW-1:0] s);
    logic [1:0] r;
    r = 2'b00;
    if (wb_rf_le && wb_rd == s) r = 2'b11;
    if (mem_rf_le && mem_rd == s) r = 2'b10;
    if (ex_rf_le && !ex_load && ex_rd == s) r = 2'b01;
    if (s == '0) r = 2'b00;
    return r;
  endfunction

  task automatic zero_inputs();
    id_ra = '0; id_rb = '0; id_use_ra = 0; id_use_rb = 0;
    ex_rd = '0; ex_rf_le = 0; ex_load = 0;
    mem_rd = '0; mem_rf_le = 0; wb_rd = '0; wb_rf_le = 0; br_taken = 0;
  endtask

  task automatic load_hazard_ra(input logic [AW-1:0] r);
    ex_load = 1; ex_rf_le = 1; ex_rd = r; id_ra = r; id_use_ra = 1;
  endtask

  // Inputs are already driven (just after a posedge); push expectations,
  // compare at the falling edge, then advance to just after the next posedge.
  task automatic step(input string tag, input logic [8:0] e1, input logic [8:0] e3);
    logic [8:0] x1, x3, o1, o3;
    exp1_q.push_back(e1);
    exp3_q.push_back(e3);
    @(negedge clk);
    o1 = {nop1, pc1, ifid1, fl1, fa1, fb1, st1};
    o3 = {nop3, pc3, ifid3, fl3, fa3, fb3, st3};
    x1 = exp1_q.pop_front();
    x3 = exp3_q.pop_front();
    n_checks++;
    assert (o1 === x1) else begin
      n_fail++;
      $error("FAIL %s lsc1 observed=%b expected=%b", tag, o1, x1);
    end
    n_checks++;
    assert (o3 === x3) else begin
      n_fail++;
      $error("FAIL %s lsc3 observed=%b expected=%b", tag, o3, x3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    zero_inputs();
    rst_n = 0;
    // In reset, with a live EX forwarding match: outputs must still be the reset values.
    id_ra = 5'd7; ex_rd = 5'd7; ex_rf_le = 1;
    step("reset", ev(C_RST, 2'b00, 2'b00, HZ_RUN), ev(C_RST, 2'b00, 2'b00, HZ_RUN));
    rst_n = 1;
    zero_inputs();
    step("idle", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Load-use on ra: 1 bubble vs 3 bubbles.
    load_hazard_ra(5'd5);
    step("lu_detect", ev(C_STALL, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_RUN));
    zero_inputs();
    step("lu_c1", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_STALL));
    step("lu_c2", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_STALL));
    step("lu_done", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Operand not read: no hazard.
    load_hazard_ra(5'd5);
    id_use_ra = 0;
    step("lu_unused", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Load-use on rb, then branch in the second stall cycle of the 3-bubble unit.
    zero_inputs();
    ex_load = 1; ex_rf_le = 1; ex_rd = 5'd9; id_rb = 5'd9; id_use_rb = 1;
    step("lu_rb", ev(C_STALL, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_RUN));
    zero_inputs();
    step("br_pre", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_STALL));
    br_taken = 1;
    step("br_in_stall", ev(C_FLUSH, 2'b00, 2'b00, HZ_RUN), ev(C_FLUSH, 2'b00, 2'b00, HZ_STALL));
    br_taken = 0;
    step("br_after", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Forwarding priority on rb.
    ex_rd = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    ex_rf_le = 1; mem_rf_le = 1; wb_rf_le = 1; id_rb = 5'd7;
    step("fwd_ex", ev(C_RUN, 2'b00, 2'b01, HZ_RUN), ev(C_RUN, 2'b00, 2'b01, HZ_RUN));
    ex_rf_le = 0;
    step("fwd_mem", ev(C_RUN, 2'b00, 2'b10, HZ_RUN), ev(C_RUN, 2'b00, 2'b10, HZ_RUN));
    mem_rf_le = 0;
    step("fwd_wb", ev(C_RUN, 2'b00, 2'b11, HZ_RUN), ev(C_RUN, 2'b00, 2'b11, HZ_RUN));
    wb_rf_le = 0;
    step("fwd_none", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // EX is a load: skip to MEM on ra.
    zero_inputs();
    id_ra = 5'd3; ex_rd = 5'd3; ex_load = 1; ex_rf_le = 1; mem_rd = 5'd3; mem_rf_le = 1;
    step("fwd_skip_load", ev(C_RUN, 2'b10, 2'b00, HZ_RUN), ev(C_RUN, 2'b10, 2'b00, HZ_RUN));

    // GR0: no stall, no forwarding.
    zero_inputs();
    load_hazard_ra(5'd0);
    mem_rf_le = 1; wb_rf_le = 1;
    step("gr0", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Load-use together with branch: flush only.
    zero_inputs();
    load_hazard_ra(5'd5);
    br_taken = 1;
    step("lu_and_br", ev(C_FLUSH, 2'b00, 2'b00, HZ_RUN), ev(C_FLUSH, 2'b00, 2'b00, HZ_RUN));
    zero_inputs();
    step("lu_and_br_next", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Reset in the middle of a 3-cycle stall.
    load_hazard_ra(5'd6);
    step("rst_lu", ev(C_STALL, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_RUN));
    zero_inputs();
    step("rst_stall", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_STALL, 2'b00, 2'b00, HZ_STALL));
    rst_n = 0;
    step("rst_mid", ev(C_RST, 2'b00, 2'b00, HZ_RUN), ev(C_RST, 2'b00, 2'b00, HZ_RUN));
    rst_n = 1;
    step("rst_release", ev(C_RUN, 2'b00, 2'b00, HZ_RUN), ev(C_RUN, 2'b00, 2'b00, HZ_RUN));

    // Randomised forwarding with no operand reads (so never a stall).
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ea, eb;
      id_ra = AW'($urandom_range(0, 3)); id_rb = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
      wb_rd = AW'($urandom_range(0, 3));
      ex_rf_le = 1'($urandom_range(0, 1)); ex_load = 1'($urandom_range(0, 1));
      mem_rf_le = 1'($urandom_range(0, 1)); wb_rf_le = 1'($urandom_range(0, 1));
      id_use_ra = 0; id_use_rb = 0; br_taken = 0;
      ea = fwd_model(id_ra);
      eb = fwd_model(id_rb);
      step("fwd_rand", ev(C_RUN, ea, eb, HZ_RUN), ev(C_RUN, ea, eb, HZ_RUN));
    end
    zero_inputs();

    // Counters were cleared by the mid-stall reset and nothing stalled or flushed since.
    @(negedge clk);
    chk16("stall_cnt1_clear", sc1, 16'd0);
    chk16("flush_cnt1_clear", fc1, 16'd0);
    chk16("stall_cnt3_clear", sc3, 16'd0);
    chk16("flush_cnt3_clear", fc3, 16'd0);

`ifdef HAZARD_STATS_EN
    // Hold a load-use hazard long enough to saturate the stall counters.
    @(posedge clk);
    #1;
    load_hazard_ra(5'd5);
    repeat (70000) @(posedge clk);
    #1;
    zero_inputs();
    br_taken = 1;
    @(posedge clk);
    #1;
    br_taken = 0;
    @(negedge clk);
    chk16("stall_cnt1_sat", sc1, 16'hFFFF);
    chk16("stall_cnt3_sat", sc3, 16'hFFFF);
    chk16("flush_cnt1_one", fc1, 16'd1);
    chk16("flush_cnt3_one", fc3, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
